// File: rtl/mult_pipe_pkg.sv
// Shared types and helpers for the pipelined multiply / multiply-accumulate unit.
package mult_pipe_pkg;

  // Bit 0 selects two's-complement operands, bit 1 selects accumulate.
  typedef enum logic [1:0] {
    MUL_U = 2'b00,
    MUL_S = 2'b01,
    MAC_U = 2'b10,
    MAC_S = 2'b11
  } op_mode_t;

  // Control fields carried alongside the product through every stage.
  typedef struct packed {
    logic     valid;
    op_mode_t mode;
    logic     first;
  } stage_ctl_t;

  function automatic logic is_signed(input op_mode_t mode);
    return mode[0];
  endfunction

  function automatic logic is_mac(input op_mode_t mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One enable-gated pipeline register for an arbitrary packed payload.
module mult_pipe_stage #(
  parameter type payload_t = logic
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  payload_t d,
  output payload_t q
);

  // NOTE: sequential state is always written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mult_pipe_mac.sv
// Pipelined signed/unsigned multiplier with optional accumulate and a single
// global stall enable driven by the output handshake.
module mult_pipe_mac
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 3,
  parameter int ACC_WIDTH   = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic                 in_first,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result
);

  localparam int PROD_W = 2*WIDTH;
  localparam int FULL_W = 2*WIDTH+2;

  typedef struct packed {
    stage_ctl_t        ctl;
    logic [PROD_W-1:0] product;
  } stage_t;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: operand capture; bubbles enter as valid=0 rather than being skipped.
  stage_ctl_t       s1_ctl;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ctl <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (en) begin
      s1_ctl.valid <= in_valid;
      s1_ctl.mode  <= op_mode_t'(in_mode);
      s1_ctl.first <= in_first;
      s1_a         <= multiplicand;
      s1_b         <= multiplier;
    end
  end

  // One signed multiplier serves both modes: unsigned operands get a zero MSB.
  logic signed [WIDTH:0]  a_ext;
  logic signed [WIDTH:0]  b_ext;
  logic signed [FULL_W-1:0] prod_full;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    a_ext     = {is_signed(s1_ctl.mode) & s1_a[WIDTH-1], s1_a};
    b_ext     = {is_signed(s1_ctl.mode) & s1_b[WIDTH-1], s1_b};
    prod_full = FULL_W'(a_ext) * FULL_W'(b_ext);
  end

  // pipe[0] is the combinational stage-1 view; pipe[PIPE_STAGES-2] feeds the output register.
  stage_t pipe [PIPE_STAGES-1];

  assign pipe[0] = '{ctl: s1_ctl, product: prod_full[PROD_W-1:0]};

  for (genvar i = 0; i < PIPE_STAGES-2; i++) begin : g_stage
    mult_pipe_stage #(.payload_t(stage_t)) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (pipe[i]),
      .q   (pipe[i+1])
    );
  end

  stage_t               fin;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;

  assign fin = pipe[PIPE_STAGES-2];

  always_comb begin
    if (is_signed(fin.ctl.mode)) begin
      ext = ACC_WIDTH'($signed(fin.product));
    end else begin
      ext = ACC_WIDTH'(fin.product);
    end
    acc_next = fin.ctl.first ? ext : acc + ext;
  end

  // The accumulator moves only when a valid MAC entry lands here, never on stalls or bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      acc       <= '0;
    end else if (en) begin
      out_valid <= fin.ctl.valid;
      if (fin.ctl.valid) begin
        if (is_mac(fin.ctl.mode)) begin
          acc    <= acc_next;
          result <= acc_next;
        end else begin
          result <= ext;
        end
      end
    end
  end

endmodule

// File: doc/mult_pipe_mac.md
# mult_pipe_mac

Parametrised, pipelined integer multiply / multiply-accumulate unit with valid/ready handshakes. It is the successor to the fixed 8×8 registered multiplier wrapper. It adds:
- configurable operand width and pipeline depth,
- per-transaction signed/unsigned selection,
- an accumulate mode,
- backpressure.

It sits between an operand-issuing datapath and a result consumer that may stall.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥2)
- PIPE_STAGES, 3, register stages from input to result (≥2; 2 matches the legacy wrapper's latency)
- ACC_WIDTH, 2*WIDTH+8, result/accumulator width (≥2*WIDTH)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand transaction present
- in_ready  out  1  unit accepts the transaction this cycle
- in_mode  in  2  00 unsigned mul, 01 signed mul, 10 unsigned MAC, 11 signed MAC
- in_first  in  1  MAC only: load accumulator instead of adding
- multiplicand  in  WIDTH  operand A
- multiplier  in  WIDTH  operand B
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result this cycle
- result  out  ACC_WIDTH  product or accumulator value

## Operation
- **Acceptance.** A transfer occurs on an edge where in_valid && in_ready.
- **Stage 1** registers operands, in_mode and in_first, plus a valid bit.
- **Product.** The full 2*WIDTH-bit product of the stage-1 operands is computed combinationally.
  - Signed modes treat both operands as two's complement.
  - Unsigned modes treat both as unsigned.
- **Stages 2..PIPE_STAGES-1** delay the product, mode and first fields.
- **Stage PIPE_STAGES** is the output/accumulator register. It holds a valid bit and result.
- **Extension.** The product is extended to ACC_WIDTH: sign-extended in signed modes, zero-extended in unsigned modes.
- **Mul modes:** result = extended product. The accumulator is untouched.
- **MAC with first=1:** acc = extended product.
- **MAC with first=0:** acc = acc + extended product, mod 2^ACC_WIDTH (silent wrap).
- **MAC output:** result = the new acc value.
- **Accumulator update rule.** The accumulator updates only when a valid MAC entry loads the final stage. It is never updated on stalls or bubbles.
- **Stall rule.**
  - Global enable: en = !out_valid || out_ready.
  - All stages advance only when en is high.
  - in_ready = en.
  - Bubbles are carried as valid=0 and are not collapsed.
- **Ordering.** Results emerge strictly in acceptance order. None are dropped or duplicated.

## Timing
- **Latency.** A transaction accepted at edge n appears with out_valid=1 after edge n+PIPE_STAGES-1, provided no stall occurs.
- **Throughput.** One transaction per cycle while out_ready=1.
- **Combinational paths.** in_ready depends combinationally on out_ready. No other combinational input-to-output path exists.
- **Stall hold.** While out_valid=1 && out_ready=0:
  - result and out_valid hold;
  - in_ready=0;
  - all stage contents hold.
- **Simultaneous pop and push.** out_ready=1 and in_valid=1 in the same cycle: both complete on the same edge.
- **Reset values.** out_valid=0, result=0, acc=0, all stage valid bits 0. in_ready reads 1 during and after reset.
- **Reset mid-operation.** In-flight transactions are discarded. Nothing is emitted after release until new inputs are accepted.
- **MAC after reset without first.** A MAC with first=0 as the first transaction after reset adds to acc=0.

## Structure
- Package mult_pipe_pkg:
  - op_mode_t enum (MUL_U, MUL_S, MAC_U, MAC_S);
  - helper predicates is_signed and is_mac;
  - a stage payload struct {valid, mode, first, product}.
- Sub-module mult_pipe_stage: one enable-gated, async-reset register holding the payload struct, instantiated PIPE_STAGES-2 times in a generate loop.
- Product logic: WIDTH+1-bit extended operands, one signed multiply, low 2*WIDTH bits kept.
- Accumulator logic lives in the top level.

## Test plan
All scenarios use WIDTH=8, PIPE_STAGES=3, ACC_WIDTH=24 unless stated otherwise.
1. **Unsigned mul.** Mode 00, 0xFF×0xFF accepted at edge 0 → out_valid after edge 2, result=0x00FE01.
2. **Signed mul.** Mode 01, 0x80×0x7F → result=0xFFC080 (−16256).
3. **Signed MAC sequence.** Back-to-back mode 11: 3×4 with first=1, then 0xFE×5, then 7×7 → results 0x00000C, 0x000002, 0x000033 on consecutive cycles.
4. **Backpressure.**
   - Stimulus: three back-to-back MAC_U inputs (2×2 with first=1, 3×3, 4×4); out_ready held low for 4 cycles after the first out_valid.
   - Required: in_ready=0 throughout the stall; result holds 0x000004; after release the bench sees 0x00000D then 0x00001D, with no acc double-update.
5. **Accumulator wrap.** ACC_WIDTH=16, mode 10: 0xFF×0xFF with first=1, then the same with first=0 → 0xFE01, then 0xFC02.
6. **Reset mid-flight.** Assert rst for 1 cycle with two transactions in flight → out_valid drops immediately; acc=0; after release no result appears until a new input is accepted.
